// File: rtl/rv32i_types.sv
// RV32I encoding enumerations shared by the decoder and its consumers.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    f3_add  = 3'b000,
    f3_sll  = 3'b001,
    f3_slt  = 3'b010,
    f3_sltu = 3'b011,
    f3_xor  = 3'b100,
    f3_sr   = 3'b101,
    f3_or   = 3'b110,
    f3_and  = 3'b111
  } arith_funct3_t;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  // funct3 -> ALU op for op_imm/op_reg; alt is instr[30].
  // Subtract only exists in register form, so addi with a negative
  // immediate (bit 30 set) must stay an add.
  function automatic alu_ops arith_to_alu(input logic [2:0] f3,
                                          input logic alt,
                                          input logic is_reg);
    alu_ops op;
    case (arith_funct3_t'(f3))
      f3_add:  op = (is_reg && alt) ? alu_sub : alu_add;
      f3_sll:  op = alu_sll;
      f3_slt:  op = alu_sub;
      f3_sltu: op = alu_sub;
      f3_xor:  op = alu_xor;
      f3_sr:   op = alt ? alu_sra : alu_srl;
      f3_or:   op = alu_or;
      f3_and:  op = alu_and;
      default: op = alu_add;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/tomasula_types.sv
// Tomasulo pipeline shared types: decoded instruction-queue entry.
package tomasula_types;
  import rv32i_types::*;

  localparam int IQ_DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    rv32i_opcode opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    alu_ops      aluop;
    logic        illegal;
  } iq_entry_t;

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I decoder: raw {pc, instr} to a decoded queue entry.
module rv32i_decoder
  import rv32i_types::*;
  import tomasula_types::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output iq_entry_t   entry
);

  // Field extraction, immediate by format, ALU op and legality check.
  always_comb begin
    entry         = '0;
    entry.pc      = pc;
    entry.instr   = instr;
    entry.opcode  = rv32i_opcode'(instr[6:0]);
    entry.funct3  = instr[14:12];
    entry.rd      = instr[11:7];
    entry.rs1     = instr[19:15];
    entry.rs2     = instr[24:20];
    entry.aluop   = alu_add;
    entry.illegal = 1'b0;
    case (rv32i_opcode'(instr[6:0]))
      op_lui, op_auipc: entry.imm = {instr[31:12], 12'b0};
      op_jal:   entry.imm = {{11{instr[31]}}, instr[31], instr[19:12],
                             instr[20], instr[30:21], 1'b0};
      op_jalr:  entry.imm = {{20{instr[31]}}, instr[31:20]};
      op_load: begin
        entry.imm = {{20{instr[31]}}, instr[31:20]};
        case (load_funct3_t'(instr[14:12]))
          lb, lh, lw, lbu, lhu: entry.illegal = 1'b0;
          default:              entry.illegal = 1'b1;
        endcase
      end
      op_store: begin
        entry.imm     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        entry.illegal = (instr[14:12] > 3'd2);
      end
      op_br: begin
        entry.imm     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                         instr[11:8], 1'b0};
        entry.illegal = (instr[14:13] == 2'b01);
      end
      op_imm: begin
        entry.imm   = {{20{instr[31]}}, instr[31:20]};
        entry.aluop = arith_to_alu(instr[14:12], instr[30], 1'b0);
      end
      op_reg:   entry.aluop = arith_to_alu(instr[14:12], instr[30], 1'b1);
      op_csr:   entry.imm = '0;
      default:  entry.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_queue_decode.sv
// Circular instruction queue between fetch and dispatch, decoding on write.
module instr_queue_decode
  import rv32i_types::*;
  import tomasula_types::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [31:0]              enq_pc,
  input  logic [31:0]              enq_instr,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [31:0]              deq_pc,
  output logic [31:0]              deq_instr,
  output logic [6:0]               deq_opcode,
  output logic [2:0]               deq_funct3,
  output logic [4:0]               deq_rd,
  output logic [4:0]               deq_rs1,
  output logic [4:0]               deq_rs2,
  output logic [31:0]              deq_imm,
  output logic [2:0]               deq_aluop,
  output logic                     deq_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  iq_entry_t        mem [DEPTH];
  iq_entry_t        dec;
  iq_entry_t        head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             enq_fire, deq_fire;

  rv32i_decoder u_dec (
    .pc    (enq_pc),
    .instr (enq_instr),
    .entry (dec)
  );

  // Ready/valid depend only on occupancy, never on the other side's handshake.
  assign enq_ready = (count < CNT_W'(DEPTH));
  assign deq_valid = (count != '0);
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = deq_valid & deq_ready;

  // Pointers and occupancy; flush wins over any handshake in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
      if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; the decoded word is captured at wr_ptr on enqueue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (enq_fire && !flush) begin
      mem[wr_ptr] <= dec;
    end
  end

  // Head fields straight from storage: no enqueue bypass.
  assign head        = mem[rd_ptr];
  assign deq_pc      = head.pc;
  assign deq_instr   = head.instr;
  assign deq_opcode  = head.opcode;
  assign deq_funct3  = head.funct3;
  assign deq_rd      = head.rd;
  assign deq_rs1     = head.rs1;
  assign deq_rs2     = head.rs2;
  assign deq_imm     = head.imm;
  assign deq_aluop   = head.aluop;
  assign deq_illegal = head.illegal;

endmodule

// File: tb/tb_instr_queue_decode.sv
// Directed bench for instr_queue_decode: decode table plus queue corner cases.
module tb_instr_queue_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_pc;
  logic [31:0] enq_instr;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_pc;
  logic [31:0] deq_instr;
  logic [6:0]  deq_opcode;
  logic [2:0]  deq_funct3;
  logic [4:0]  deq_rd;
  logic [4:0]  deq_rs1;
  logic [4:0]  deq_rs2;
  logic [31:0] deq_imm;
  logic [2:0]  deq_aluop;
  logic        deq_illegal;
  logic [3:0]  count;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  instr_queue_decode #(.DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_pc      (enq_pc),
    .enq_instr   (enq_instr),
    .deq_valid   (deq_valid),
    .deq_ready   (deq_ready),
    .deq_pc      (deq_pc),
    .deq_instr   (deq_instr),
    .deq_opcode  (deq_opcode),
    .deq_funct3  (deq_funct3),
    .deq_rd      (deq_rd),
    .deq_rs1     (deq_rs1),
    .deq_rs2     (deq_rs2),
    .deq_imm     (deq_imm),
    .deq_aluop   (deq_aluop),
    .deq_illegal (deq_illegal),
    .count       (count)
  );

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [2:0]  aluop;
    logic        ill;
    logic        chk_imm;
  } vec_t;

  vec_t        vecs [16];
  logic [31:0] mq [$];
  logic [31:0] next_pc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    enq_valid = 1'b1;
    enq_pc    = pc;
    enq_instr = ins;
    tick();
    enq_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // instr, opcode, funct3, rd, rs1, rs2, imm, aluop, illegal, check imm
    vecs[0]  = '{32'h40B50533, 7'h33, 3'd0, 5'd10, 5'd10, 5'd11, 32'h00000000, 3'd3, 1'b0, 1'b1};
    vecs[1]  = '{32'hFFC10113, 7'h13, 3'd0, 5'd2,  5'd2,  5'd28, 32'hFFFFFFFC, 3'd0, 1'b0, 1'b1};
    vecs[2]  = '{32'hFE0008E3, 7'h63, 3'd0, 5'd17, 5'd0,  5'd0,  32'hFFFFFFF0, 3'd0, 1'b0, 1'b1};
    vecs[3]  = '{32'h0000007F, 7'h7F, 3'd0, 5'd0,  5'd0,  5'd0,  32'h00000000, 3'd0, 1'b1, 1'b0};
    vecs[4]  = '{32'h123452B7, 7'h37, 3'd5, 5'd5,  5'd8,  5'd3,  32'h12345000, 3'd0, 1'b0, 1'b1};
    vecs[5]  = '{32'h40315093, 7'h13, 3'd5, 5'd1,  5'd2,  5'd3,  32'h00000403, 3'd2, 1'b0, 1'b1};
    vecs[6]  = '{32'h00512423, 7'h23, 3'd2, 5'd8,  5'd2,  5'd5,  32'h00000008, 3'd0, 1'b0, 1'b1};
    vecs[7]  = '{32'h00513423, 7'h23, 3'd3, 5'd8,  5'd2,  5'd5,  32'h00000008, 3'd0, 1'b1, 1'b1};
    vecs[8]  = '{32'hFFDFF06F, 7'h6F, 3'd7, 5'd0,  5'd31, 5'd29, 32'hFFFFFFFC, 3'd0, 1'b0, 1'b1};
    vecs[9]  = '{32'h00013083, 7'h03, 3'd3, 5'd1,  5'd2,  5'd0,  32'h00000000, 3'd0, 1'b1, 1'b1};
    vecs[10] = '{32'h00002063, 7'h63, 3'd2, 5'd0,  5'd0,  5'd0,  32'h00000000, 3'd0, 1'b1, 1'b1};
    vecs[11] = '{32'h005241B3, 7'h33, 3'd4, 5'd3,  5'd4,  5'd5,  32'h00000000, 3'd4, 1'b0, 1'b1};
    vecs[12] = '{32'hFFFFF397, 7'h17, 3'd7, 5'd7,  5'd31, 5'd31, 32'hFFFFF000, 3'd0, 1'b0, 1'b1};
    vecs[13] = '{32'h0040A183, 7'h03, 3'd2, 5'd3,  5'd1,  5'd4,  32'h00000004, 3'd0, 1'b0, 1'b1};
    vecs[14] = '{32'h00512093, 7'h13, 3'd2, 5'd1,  5'd2,  5'd5,  32'h00000005, 3'd3, 1'b0, 1'b1};
    vecs[15] = '{32'h003150B3, 7'h33, 3'd5, 5'd1,  5'd2,  5'd3,  32'h00000000, 3'd5, 1'b0, 1'b1};

    rst = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    enq_pc = '0; enq_instr = '0;
    #3;
    chk("reset count", 32'(count), 32'd0);
    chk("reset deq_valid", 32'(deq_valid), 32'd0);
    chk("reset enq_ready", 32'(enq_ready), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    chk("idle count", 32'(count), 32'd0);
    chk("idle deq_valid", 32'(deq_valid), 32'd0);
    chk("idle enq_ready", 32'(enq_ready), 32'd1);

    // Decode table: each entry goes through an empty queue on its own.
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("v%0d enq_ready", i), 32'(enq_ready), 32'd1);
      push(32'h100 + 32'(i * 4), vecs[i].instr);
      chk($sformatf("v%0d deq_valid", i), 32'(deq_valid), 32'd1);
      chk($sformatf("v%0d count", i), 32'(count), 32'd1);
      chk($sformatf("v%0d pc", i), deq_pc, 32'h100 + 32'(i * 4));
      chk($sformatf("v%0d instr", i), deq_instr, vecs[i].instr);
      chk($sformatf("v%0d opcode", i), 32'(deq_opcode), 32'(vecs[i].opc));
      chk($sformatf("v%0d funct3", i), 32'(deq_funct3), 32'(vecs[i].f3));
      chk($sformatf("v%0d rd", i), 32'(deq_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d rs1", i), 32'(deq_rs1), 32'(vecs[i].rs1));
      chk($sformatf("v%0d rs2", i), 32'(deq_rs2), 32'(vecs[i].rs2));
      if (vecs[i].chk_imm) chk($sformatf("v%0d imm", i), deq_imm, vecs[i].imm);
      chk($sformatf("v%0d aluop", i), 32'(deq_aluop), 32'(vecs[i].aluop));
      chk($sformatf("v%0d illegal", i), 32'(deq_illegal), 32'(vecs[i].ill));
      deq_ready = 1'b1;
      tick();
      deq_ready = 1'b0;
      chk($sformatf("v%0d drained", i), 32'(count), 32'd0);
      chk($sformatf("v%0d deq_valid off", i), 32'(deq_valid), 32'd0);
    end

    // Illegal entry sits between two legal ones and leaves in order.
    push(32'h200, 32'h00512093);
    push(32'h204, 32'h0000007F);
    push(32'h208, 32'h40B50533);
    chk("ord count", 32'(count), 32'd3);
    deq_ready = 1'b1;
    chk("ord pc0", deq_pc, 32'h200);
    chk("ord ill0", 32'(deq_illegal), 32'd0);
    tick();
    chk("ord pc1", deq_pc, 32'h204);
    chk("ord ill1", 32'(deq_illegal), 32'd1);
    tick();
    chk("ord pc2", deq_pc, 32'h208);
    chk("ord ill2", 32'(deq_illegal), 32'd0);
    tick();
    deq_ready = 1'b0;
    chk("ord empty", 32'(count), 32'd0);

    // Fill to DEPTH, then a full-cycle push/pop, then sustained push/pop across the wrap.
    next_pc = 32'h1000;
    for (int k = 0; k < 8; k++) begin
      push(next_pc, 32'h00000013);
      mq.push_back(next_pc);
      next_pc += 32'd4;
    end
    chk("full count", 32'(count), 32'd8);
    chk("full enq_ready", 32'(enq_ready), 32'd0);
    chk("full deq_valid", 32'(deq_valid), 32'd1);
    enq_valid = 1'b1; enq_pc = next_pc; enq_instr = 32'h00000013;
    deq_ready = 1'b1;
    chk("full head", deq_pc, mq[0]);
    tick();
    void'(mq.pop_front());
    chk("full pop count", 32'(count), 32'd7);
    chk("full pop enq_ready", 32'(enq_ready), 32'd1);
    for (int k = 0; k < 20; k++) begin
      enq_pc = next_pc;
      chk($sformatf("wrap%0d head", k), deq_pc, mq[0]);
      chk($sformatf("wrap%0d count", k), 32'(count), 32'd7);
      tick();
      void'(mq.pop_front());
      mq.push_back(next_pc);
      next_pc += 32'd4;
    end
    enq_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("drain%0d head", k), deq_pc, mq[0]);
      tick();
      void'(mq.pop_front());
    end
    deq_ready = 1'b0;
    chk("drain count", 32'(count), 32'd0);

    // Flush with 5 entries and both handshakes offered.
    for (int k = 0; k < 5; k++) push(32'h3000 + 32'(k * 4), 32'h00000013);
    chk("pre-flush count", 32'(count), 32'd5);
    flush = 1'b1; enq_valid = 1'b1; enq_pc = 32'h4000; deq_ready = 1'b1;
    chk("flush head valid", 32'(deq_valid), 32'd1);
    chk("flush head pc", deq_pc, 32'h3000);
    tick();
    flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    chk("post-flush count", 32'(count), 32'd0);
    chk("post-flush deq_valid", 32'(deq_valid), 32'd0);
    chk("post-flush enq_ready", 32'(enq_ready), 32'd1);
    push(32'h5000, 32'h00000013);
    chk("after flush count", 32'(count), 32'd1);
    chk("after flush head", deq_pc, 32'h5000);
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;

    // Asynchronous reset mid-cycle with 3 entries held.
    for (int k = 0; k < 3; k++) push(32'h6000 + 32'(k * 4), 32'h00000013);
    chk("pre-rst count", 32'(count), 32'd3);
    @(posedge clk);
    #4;
    rst = 1'b0;
    #1;
    chk("async rst count", 32'(count), 32'd0);
    chk("async rst deq_valid", 32'(deq_valid), 32'd0);
    chk("async rst enq_ready", 32'(enq_ready), 32'd1);
    #2;
    rst = 1'b1;
    tick();
    chk("after rst count", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
